angular_pred_accum: RTL and testbench
=====================================

Name: angular_pred_accum

Overview:
- Consumer end of the MCM product interface in the intra angular predictor.
- Accepts one set of four signed tap products per predicted sample; the products come from the multiplier blocks (Y1/Y2-style 16-bit outputs).
- Reduces them through a 3-stage valid/ready pipeline, then rounds, normalises and clips to an 8-bit predicted sample.
- Tracks samples per block and flags block completion; sits between the MCM array and the prediction-buffer writer.

Parameters:
- PW, 16: width of each signed input product.
- BW, 8: output sample bit depth.
- SHIFT, 6: normalisation shift (filter coefficients sum to 64).
- CW, 6: width of the per-block sample counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  product set valid.
- in_ready  out  1  accumulator can accept a product set.
- in_last  in  1  this product set is the last sample of the block.
- p0, p1, p2, p3  in  PW each  signed tap products.
- out_valid  out  1  predicted sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_sample  out  BW  clipped, rounded predicted sample (unsigned).
- out_last  out  1  sample is the last of its block.
- out_idx  out  CW  index of out_sample within its block.
- block_done  out  1  one-cycle pulse when a last sample is accepted downstream.

Behaviour:
- Reset (async assert, sync release): all stage valids 0, out_valid 0, out_sample 0, out_last 0, out_idx 0, block_done 0. Pipeline contents are discarded when reset is asserted mid-operation.
- Handshakes:
  - Input transfer on in_valid && in_ready.
  - Output transfer on out_valid && out_ready.
  - out_* are held stable while out_valid && !out_ready.
- Pipeline:
  - S1: s01 = p0+p1, s23 = p2+p3, sign-extended to PW+1.
  - S2: sum = s01+s23 (PW+2 bits signed) + (1<<(SHIFT-1)).
  - S3: arithmetic shift right by SHIFT, then clip to [0, 2^BW-1]. This is the output register.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput 1 sample per cycle.
- Stage advance rule: stage k loads when stage k is empty or stage k's contents move on in the same cycle.
  - in_ready = !s1_valid || s1_moves; it is combinational from out_ready through the chain.
- Full pipeline with out_ready=0: in_ready=0 and all three stages hold. When out_ready rises, every stage shifts in the same cycle.
- Bubbles: an empty stage collapses. A new input is accepted while a downstream stage is empty even if out_ready=0.
- last flag: travels with its data through every stage.
- out_idx:
  - Increments after each output transfer.
  - Returns to 0 after a transfer with out_last=1.
  - On a non-last transfer at 2^CW-1 it wraps modulo 2^CW.
- block_done: asserted in the cycle after an output transfer with out_last=1. A last and a new first sample in consecutive cycles are both handled with no gap.
- Arithmetic:
  - The sum cannot overflow at PW+2 bits.
  - Negative results clip to 0.
  - Results above 2^BW-1 clip to 2^BW-1.

Decomposition:
- Shared package angular_pkg: PW, BW, SHIFT, CW defaults; ROUND_OFS = 1<<(SHIFT-1); MAX_SAMPLE = 2^BW-1.
- Sub-module pipe_stage: a generic valid/ready register slice, instantiated three times with the payload width as its parameter.
- Adder, round and clip logic stays in the top-level module.

Test Plan:
- p=(0,3600,2400,400), in_last=0, out_ready=1 -> after 3 cycles out_sample=100, out_idx=0.
- Rounding: sum 95 -> out_sample=1; sum 31 -> out_sample=0; sum 32 -> out_sample=1.
- Clipping: p=(-2000,0,0,0) -> 0; p=(32767,32767,32767,32767) -> 255.
- Backpressure: stream 8 sets with out_ready=0.
  - Exactly 3 are accepted, then in_ready=0.
  - Outputs are held stable.
  - When out_ready=1 all 8 emerge in order, none lost or duplicated.
- Block of 4 with in_last on the 4th, followed immediately by a new block -> out_idx 0,1,2,3,0; block_done pulses once, the cycle after idx 3 transfers.
- Assert rst with 2 samples in flight -> out_valid=0 immediately; no stale sample appears after release; out_idx=0.

Source files
------------

// File: rtl/angular_pkg.sv
// Shared constants for the angular-predictor product accumulator: default widths,
// rounding offset and the largest representable predicted sample.
package angular_pkg;

   localparam int PW    = 16;
   localparam int BW    = 8;
   localparam int SHIFT = 6;
   localparam int CW    = 6;

   function automatic int round_ofs(input int shift);
      return 32'sd1 << (shift - 32'sd1);
   endfunction

   function automatic int max_sample(input int bw);
      return (32'sd1 << bw) - 32'sd1;
   endfunction

   localparam int ROUND_OFS  = round_ofs(SHIFT);
   localparam int MAX_SAMPLE = max_sample(BW);

endpackage

// File: rtl/angular_pred_accum_pipe_stage.sv
// Generic valid/ready register slice: loads whenever empty or when its own
// contents leave in the same cycle, so bubbles collapse and full throughput holds.
module pipe_stage
   import angular_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [W-1:0] i_data,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [W-1:0] o_data
);

   logic         r_valid;
   logic [W-1:0] r_data;

   assign o_ready = !r_valid || i_ready;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Slice register: payload only captured on an actual transfer in.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_data  <= {W{1'b0}};
      end else if (o_ready) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/angular_pred_accum.sv
// Reduces four signed tap products per sample through a 3-slice pipeline, then
// rounds, normalises and clips to an unsigned predicted sample with block tracking.
module angular_pred_accum
   import angular_pkg::*;
#(
   parameter int PW    = angular_pkg::PW,
   parameter int BW    = angular_pkg::BW,
   parameter int SHIFT = angular_pkg::SHIFT,
   parameter int CW    = angular_pkg::CW
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   input  logic signed [PW-1:0] p0,
   input  logic signed [PW-1:0] p1,
   input  logic signed [PW-1:0] p2,
   input  logic signed [PW-1:0] p3,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BW-1:0]        out_sample,
   output logic                 out_last,
   output logic [CW-1:0]        out_idx,
   output logic                 block_done
);

   // One guard bit beyond PW+2 so the rounding offset cannot wrap a full-scale sum.
   localparam int SW  = PW + 3;
   localparam int W1  = 2 * PW + 3;
   localparam int W2  = SW + 1;
   localparam int W3  = BW + 1;
   localparam int RND = round_ofs(SHIFT);
   localparam logic [BW-1:0] L_MAX = BW'(max_sample(BW));

   logic [PW:0]   w_s01;
   logic [PW:0]   w_s23;
   logic [W1-1:0] w_s1_d;
   logic [W1-1:0] w_s1_q;
   logic          w_s1_valid;
   logic          w_s2_ready;

   logic [PW:0]   w_s01_q;
   logic [PW:0]   w_s23_q;
   logic [SW-1:0] w_sum;
   logic [W2-1:0] w_s2_d;
   logic [W2-1:0] w_s2_q;
   logic          w_s2_valid;
   logic          w_s3_ready;

   logic signed [SW-1:0] w_shifted;
   logic [BW-1:0] w_clip;
   logic [W3-1:0] w_s3_d;
   logic [W3-1:0] w_s3_q;
   logic          w_out_fire;

   logic [CW-1:0] r_idx;
   logic          r_block_done;

   assign w_s01  = {p0[PW-1], p0} + {p1[PW-1], p1};
   assign w_s23  = {p2[PW-1], p2} + {p3[PW-1], p3};
   assign w_s1_d = {in_last, w_s01, w_s23};

   pipe_stage #(.W(W1)) u_s1 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (in_valid),
      .o_ready (in_ready),
      .i_data  (w_s1_d),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_ready),
      .o_data  (w_s1_q)
   );

   assign w_s01_q = w_s1_q[2*PW+1:PW+1];
   assign w_s23_q = w_s1_q[PW:0];
   assign w_sum   = {{2{w_s01_q[PW]}}, w_s01_q} + {{2{w_s23_q[PW]}}, w_s23_q} + SW'(RND);
   assign w_s2_d  = {w_s1_q[W1-1], w_sum};

   pipe_stage #(.W(W2)) u_s2 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_ready),
      .i_data  (w_s2_d),
      .o_valid (w_s2_valid),
      .i_ready (w_s3_ready),
      .o_data  (w_s2_q)
   );

   assign w_shifted = $signed(w_s2_q[SW-1:0]) >>> SHIFT;

   // Clip the normalised value into the unsigned sample range.
   always_comb begin
      w_clip = {BW{1'b0}};
      if (w_shifted[SW-1]) begin
         w_clip = {BW{1'b0}};
      end else if (|w_shifted[SW-2:BW]) begin
         w_clip = L_MAX;
      end else begin
         w_clip = w_shifted[BW-1:0];
      end
   end

   assign w_s3_d = {w_s2_q[W2-1], w_clip};

   pipe_stage #(.W(W3)) u_s3 (
      .clk     (clk),
      .rst     (rst),
      .i_valid (w_s2_valid),
      .o_ready (w_s3_ready),
      .i_data  (w_s3_d),
      .o_valid (out_valid),
      .i_ready (out_ready),
      .o_data  (w_s3_q)
   );

   assign out_last   = w_s3_q[BW];
   assign out_sample = w_s3_q[BW-1:0];
   assign w_out_fire = out_valid && out_ready;

   // Sample index within the block and the completion pulse after a last transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx        <= {CW{1'b0}};
         r_block_done <= 1'b0;
      end else begin
         r_block_done <= w_out_fire && out_last;
         if (w_out_fire) begin
            if (out_last) begin
               r_idx <= {CW{1'b0}};
            end else begin
               r_idx <= r_idx + {{(CW-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   assign out_idx    = r_idx;
   assign block_done = r_block_done;

endmodule

// File: tb/tb_angular_pred_accum.sv
// Directed self-checking bench for angular_pred_accum.
module tb_angular_pred_accum;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic signed [15:0] p0, p1, p2, p3;
   logic               out_valid;
   logic               out_ready;
   logic [7:0]         out_sample;
   logic               out_last;
   logic [5:0]         out_idx;
   logic               block_done;

   int checks = 0;
   int errors = 0;

   angular_pred_accum dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_last    (in_last),
      .p0         (p0),
      .p1         (p1),
      .p2         (p2),
      .p3         (p3),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_sample (out_sample),
      .out_last   (out_last),
      .out_idx    (out_idx),
      .block_done (block_done)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic signed [15:0] a, b, c, d, input logic last, output bit ok);
      ok = 1'b0;
      p0 = a; p1 = b; p2 = c; p3 = d; in_last = last; in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         ok = in_ready;
         cyc();
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (out_valid) begin
            ok = 1'b1;
            break;
         end
         cyc();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      p0 = 16'sd0; p1 = 16'sd0; p2 = 16'sd0; p3 = 16'sd0;
      cyc(); cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_sample !== 8'd0) begin errors++; $display("FAIL reset_sample got %0d want 0", out_sample); end
      checks++; if (out_idx !== 6'd0 || out_last !== 1'b0 || block_done !== 1'b0) begin
         errors++; $display("FAIL reset_flags idx %0d last %b done %b want 0 0 0", out_idx, out_last, block_done); end
      rst = 1'b0;
      cyc();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_release in_ready %b out_valid %b want 1 0", in_ready, out_valid); end
   endtask

   task automatic test_basic();
      bit ok;
      out_ready = 1'b1;
      push(16'sd0, 16'sd3600, 16'sd2400, 16'sd400, 1'b0, ok);
      checks++; if (!ok) begin errors++; $display("FAIL basic_accept got timeout want accept"); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat1 got %b want 0", out_valid); end
      cyc();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_lat2 got %b want 0", out_valid); end
      cyc();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_lat3 got %b want 1", out_valid); end
      checks++; if (out_sample !== 8'd100 || out_idx !== 6'd0 || out_last !== 1'b0) begin
         errors++; $display("FAIL basic_value sample %0d idx %0d last %b want 100 0 0", out_sample, out_idx, out_last); end
   endtask

   task automatic test_rounding();
      bit ok;
      logic signed [15:0] sums [3];
      logic [7:0] exp_s [3];
      sums[0] = 16'sd95; sums[1] = 16'sd31; sums[2] = 16'sd32;
      exp_s[0] = 8'd1;   exp_s[1] = 8'd0;   exp_s[2] = 8'd1;
      for (int k = 0; k < 3; k++) begin
         push(sums[k], 16'sd0, 16'sd0, 16'sd0, 1'b0, ok);
         wait_out(ok);
         checks++; if (!ok) begin errors++; $display("FAIL round_timeout_%0d got none want sample", k); end
         checks++; if (out_sample !== exp_s[k] || out_idx !== 6'(k + 1)) begin
            errors++; $display("FAIL round_%0d sample %0d idx %0d want %0d %0d", k, out_sample, out_idx, exp_s[k], k + 1); end
      end
   endtask

   task automatic test_clip();
      bit ok;
      push(-16'sd2000, 16'sd0, 16'sd0, 16'sd0, 1'b0, ok);
      wait_out(ok);
      checks++; if (!ok || out_sample !== 8'd0 || out_idx !== 6'd4) begin
         errors++; $display("FAIL clip_low valid %b sample %0d idx %0d want 1 0 4", ok, out_sample, out_idx); end
      push(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 1'b1, ok);
      wait_out(ok);
      checks++; if (!ok || out_sample !== 8'd255 || out_last !== 1'b1 || out_idx !== 6'd5) begin
         errors++; $display("FAIL clip_high valid %b sample %0d last %b idx %0d want 1 255 1 5", ok, out_sample, out_last, out_idx); end
      cyc();
      checks++; if (out_idx !== 6'd0 || block_done !== 1'b1) begin
         errors++; $display("FAIL clip_idx_wrap idx %0d done %b want 0 1", out_idx, block_done); end
      cyc();
   endtask

   task automatic test_backpressure();
      int acc = 0;
      int n = 0;
      logic [7:0] rcv [8];
      logic [5:0] ridx [8];
      logic       rl [8];
      out_ready = 1'b0;
      for (int c = 0; c < 8; c++) begin
         p0 = 16'((10 + acc) * 64); p1 = 16'sd0; p2 = 16'sd0; p3 = 16'sd0;
         in_last = (acc == 7); in_valid = 1'b1;
         #1;
         if (in_ready) acc++;
         cyc();
      end
      #1;
      checks++; if (acc !== 3 || in_ready !== 1'b0) begin
         errors++; $display("FAIL bp_accept accepted %0d in_ready %b want 3 0", acc, in_ready); end
      cyc(); cyc();
      checks++; if (out_valid !== 1'b1 || out_sample !== 8'd10 || out_idx !== 6'd0) begin
         errors++; $display("FAIL bp_hold valid %b sample %0d idx %0d want 1 10 0", out_valid, out_sample, out_idx); end
      out_ready = 1'b1;
      for (int c = 0; c < 30 && n < 8; c++) begin
         if (acc < 8) begin
            p0 = 16'((10 + acc) * 64); in_last = (acc == 7); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (out_valid) begin
            rcv[n] = out_sample; ridx[n] = out_idx; rl[n] = out_last; n++;
         end
         if (in_valid && in_ready) acc++;
         cyc();
      end
      in_valid = 1'b0;
      checks++; if (n !== 8) begin errors++; $display("FAIL bp_count got %0d want 8", n); end
      for (int k = 0; k < n; k++) begin
         checks++; if (rcv[k] !== 8'(10 + k) || ridx[k] !== 6'(k) || rl[k] !== (k == 7)) begin
            errors++; $display("FAIL bp_order_%0d sample %0d idx %0d last %b want %0d %0d %b", k, rcv[k], ridx[k], rl[k], 10 + k, k, (k == 7)); end
      end
      checks++; if (out_idx !== 6'd0 || block_done !== 1'b1) begin
         errors++; $display("FAIL bp_done idx %0d done %b want 0 1", out_idx, block_done); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int acc = 0;
      int n = 0;
      int pulses = 0;
      int pos = -1;
      logic [5:0] ridx [8];
      logic [5:0] exp_idx [5];
      exp_idx[0] = 6'd0; exp_idx[1] = 6'd1; exp_idx[2] = 6'd2; exp_idx[3] = 6'd3; exp_idx[4] = 6'd0;
      out_ready = 1'b1;
      for (int c = 0; c < 14; c++) begin
         if (acc < 5) begin
            p0 = 16'((40 + acc) * 64); in_last = (acc == 3); in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (block_done) begin
            pulses++; pos = n;
         end
         if (out_valid && n < 8) begin
            ridx[n] = out_idx; n++;
         end
         if (in_valid && in_ready) acc++;
         cyc();
      end
      in_valid = 1'b0;
      checks++; if (n !== 5) begin errors++; $display("FAIL b2b_count got %0d want 5", n); end
      for (int k = 0; k < 5 && k < n; k++) begin
         checks++; if (ridx[k] !== exp_idx[k]) begin
            errors++; $display("FAIL b2b_idx_%0d got %0d want %0d", k, ridx[k], exp_idx[k]); end
      end
      checks++; if (pulses !== 1 || pos !== 4) begin
         errors++; $display("FAIL b2b_done pulses %0d at %0d want 1 at 4", pulses, pos); end
   endtask

   task automatic test_reset_midflight();
      int seen = 0;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         p0 = 16'((60 + k) * 64); in_last = 1'b0; in_valid = 1'b1;
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      checks++; if (out_valid !== 1'b1 || out_sample !== 8'd60) begin
         errors++; $display("FAIL rstmid_pre valid %b sample %0d want 1 60", out_valid, out_sample); end
      rst = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || out_idx !== 6'd0) begin
         errors++; $display("FAIL rstmid_async valid %b idx %0d want 0 0", out_valid, out_idx); end
      cyc();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (out_valid) seen++;
         cyc();
      end
      checks++; if (seen !== 0 || out_idx !== 6'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL rstmid_stale seen %0d idx %0d in_ready %b want 0 0 1", seen, out_idx, in_ready); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_clip();
      test_backpressure();
      test_back_to_back();
      test_reset_midflight();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1);
   end

endmodule
